// File: rtl/controla_so_multicanal.sv
// controla_so_multicanal
// Multi-channel system-control block. Tracks BIOS/OS mode (sel_bios) and
// stalls the CPU (bloq_cpu) while it waits for input on one of NUM_CH
// channels. Input that arrives before the CPU asks for it is remembered per
// channel in pend, so a later request on that channel completes without a
// stall.
//
// Optional feature: define CONTROLA_TIMEOUT_EN to compile in a wait timer
// that forces release after TIMEOUT_CYC cycles in BLOCK and pulses timeout
// for one cycle. Without the macro there is no timer, BLOCK is left only on
// ready or reset, and timeout is tied low.
//
// Handshake: a request is wait_req[i] sampled high on a rising edge; it is
// acknowledged either in the same edge (pend[i] or ready[i] already high, no
// stall) or by entering BLOCK, which holds until ready[canal_ativo] is sampled
// high on a later edge. wait_req is ignored while in BLOCK, so a new request
// is only taken after at least one IDLE cycle.
//
// The block FSM has two states, so bloq_cpu is the registered state itself
// and doubles as the FSM state observation point.

module controla_so_multicanal #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int TIMEOUT_CYC = 1000,
   parameter int TMR_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic [NUM_CH-1:0] wait_req,
   input  logic [NUM_CH-1:0] ready,
   output logic              sel_bios,
   output logic              bloq_cpu,
   output logic [CH_W-1:0]   canal_ativo,
   output logic [NUM_CH-1:0] pend,
   output logic              timeout
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BLOCK = 1'b1;

   logic              bios_q;
   logic              bios_d;
   logic [0:0]        st_q;
   logic [0:0]        st_d;
   logic [CH_W-1:0]   canal_q;
   logic [CH_W-1:0]   canal_d;
   logic [NUM_CH-1:0] pend_q;
   logic [NUM_CH-1:0] pend_d;

   // Priority-encoder result: lowest requesting channel.
   logic              sel_valid;
   logic [CH_W-1:0]   sel_idx;
   // Channel whose ready is consumed this cycle and therefore never latched.
   logic [NUM_CH-1:0] excl_mask;

`ifdef CONTROLA_TIMEOUT_EN
   logic [TMR_W-1:0]  tmr_q;
   logic [TMR_W-1:0]  tmr_d;
   logic              timeout_q;
   logic              timeout_d;
   logic              tmo_hit;

   // Last cycle of the allowed wait: the release edge is TIMEOUT_CYC edges
   // after the entry edge, when the timer still shows TIMEOUT_CYC-1.
   assign tmo_hit = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`else
   logic              unused_cfg;

   // Timer parameters have no effect in this build.
   assign unused_cfg = (TIMEOUT_CYC > 0) ^ (TMR_W > 0);
`endif

   // Mode register: leaves BIOS on halt and only reset brings it back.
   always_comb begin
      bios_d = bios_q;
      if (halt) begin
         bios_d = 1'b0;
      end
   end

   // Lowest-index channel with a pending wait request.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (wait_req[i]) begin
            sel_valid = 1'b1;
            sel_idx   = CH_W'(i);
         end
      end
   end

   // Mark the channel that owns ready this cycle: the selected one in IDLE,
   // the active one in BLOCK.
   always_comb begin
      excl_mask = '0;
      if (st_q == ST_BLOCK) begin
         excl_mask[canal_q] = 1'b1;
      end else if (sel_valid) begin
         excl_mask[sel_idx] = 1'b1;
      end
   end

   // Early-ready flags: every unconsumed ready sets its flag. The owning
   // channel always ends the cycle clear: in IDLE it is either consumed now
   // or it blocks (and then it was clear already); in BLOCK it cannot have
   // been set since entry required it clear.
   always_comb begin
      pend_d = (pend_q | ready) & ~excl_mask;
   end

   // Block FSM next state, active channel capture and optional timer.
   always_comb begin
      st_d    = st_q;
      canal_d = canal_q;
`ifdef CONTROLA_TIMEOUT_EN
      tmr_d     = tmr_q;
      timeout_d = 1'b0;
`endif
      case (st_q)
         ST_IDLE: begin
            if (sel_valid && !(pend_q[sel_idx] || ready[sel_idx])) begin
               st_d    = ST_BLOCK;
               canal_d = sel_idx;
`ifdef CONTROLA_TIMEOUT_EN
               tmr_d   = '0;
`endif
            end
         end
         ST_BLOCK: begin
            if (ready[canal_q]) begin
               st_d = ST_IDLE;
            end
`ifdef CONTROLA_TIMEOUT_EN
            else if (tmo_hit) begin
               st_d      = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
`endif
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   // Mode register state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bios_q <= 1'b1;
      end else begin
         bios_q <= bios_d;
      end
   end

   // FSM state and active channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= ST_IDLE;
         canal_q <= '0;
      end else begin
         st_q    <= st_d;
         canal_q <= canal_d;
      end
   end

   // Per-channel early-ready flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

`ifdef CONTROLA_TIMEOUT_EN
   // Wait timer and registered one-cycle timeout pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign sel_bios    = bios_q;
   assign bloq_cpu    = (st_q == ST_BLOCK);
   assign canal_ativo = canal_q;
   assign pend        = pend_q;

endmodule

// File: doc/controla_so_multicanal.md
# controla_so_multicanal

Multi-channel successor of the processor's system-control block: tracks BIOS/OS mode and stalls the CPU while it waits on any of `NUM_CH` input channels. Sits beside the CPU core; `sel_bios` drives instruction-memory selection and `bloq_cpu` drives the pipeline-stall/PC-hold logic. Adds per-channel early-ready latching, active-channel reporting and an optional wait timeout.

## Interface
- `NUM_CH`, 4: number of I/O channels (≥2).
- `CH_W`, 2: width of channel index, equals ceil(log2(NUM_CH)).
- `TIMEOUT_CYC`, 1000: cycles in BLOCK before forced release (≥2); only used with timeout compiled in.
- `TMR_W`, 16: timeout counter width; must hold `TIMEOUT_CYC`.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `halt` in 1: BIOS finished; level sampled each edge.
- `wait_req` in NUM_CH: CPU requests to block on channel i.
- `ready` in NUM_CH: user confirms input on channel i.
- `sel_bios` out 1: 1 = BIOS memory selected.
- `bloq_cpu` out 1: 1 = CPU stalled.
- `canal_ativo` out CH_W: channel being waited on (valid while `bloq_cpu`=1, holds last value otherwise).
- `pend` out NUM_CH: per-channel early-ready flags.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- Mode register `bios_mode`: reset → 1; `halt`=1 while 1 → 0; `halt` otherwise ignored. Only reset returns to BIOS. `sel_bios` = `bios_mode` (registered).
- Block FSM, two states, independent of mode (blocking allowed in BIOS and OS):
  - IDLE: selects lowest-index i with `wait_req[i]`=1. If `pend[i]`=1 or `ready[i]`=1 this cycle: stay IDLE, clear `pend[i]` (input already available, no stall). Else → BLOCK, `canal_ativo`←i, timer←0.
  - BLOCK: `ready[canal_ativo]`=1 → IDLE. Timer reaching `TIMEOUT_CYC`-1 (timeout build) → IDLE, pulse `timeout`. `ready` wins over timeout in the same cycle (no pulse). All `wait_req` ignored.
- `pend[j]` set by `ready[j]`=1 whenever j is not consumed that cycle (not the active channel in BLOCK, not the selected channel in IDLE); cleared only by consumption or reset. Setting an already-set flag is a no-op.
- `bloq_cpu` = (state == BLOCK), decoded from registered state.
- Reset mid-block: immediate release, all flags cleared, BIOS mode.

## Timing
- Reset values: `sel_bios`=1, `bloq_cpu`=0, `canal_ativo`=0, `pend`=0, `timeout`=0, state IDLE, timer 0.
- `wait_req` sampled at edge k → `bloq_cpu`=1 from edge k.
- `ready` on active channel sampled at edge m → `bloq_cpu`=0 from edge m; CPU resumes next cycle.
- Timeout: BLOCK entered at edge k → `bloq_cpu`=0 and `timeout`=1 from edge k+`TIMEOUT_CYC`, `timeout`=0 after following edge.
- `halt` sampled at edge k → `sel_bios`=0 from edge k.
- New block request accepted the cycle after release (one IDLE cycle minimum).

## Configuration
- `CONTROLA_TIMEOUT_EN` defined: timer and forced release as above.
- Undefined: no timer logic; BLOCK exits only on `ready` or reset; `timeout` tied 0; `TIMEOUT_CYC`/`TMR_W` unused.

## Test plan
- Reset low then high → `sel_bios`=1, `bloq_cpu`=0, `pend`=0; `halt` pulse → `sel_bios`=0; second `halt` → stays 0.
- `wait_req`=4'b0100 one cycle → `bloq_cpu`=1, `canal_ativo`=2; `ready`=4'b0001 → still blocked, `pend`=4'b0001; `ready`=4'b0100 → `bloq_cpu`=0.
- `ready`=4'b1000 while IDLE → `pend[3]`=1; later `wait_req`=4'b1000 → `bloq_cpu` stays 0, `pend[3]` cleared.
- `wait_req`=4'b0110 → `canal_ativo`=1; same-cycle `wait_req[0]`+`ready[0]` in IDLE → no stall, `pend[0]`=0.
- Timeout build, `TIMEOUT_CYC`=8: block, no ready → release exactly 8 cycles after entry with one-cycle `timeout`; repeat with `ready` on cycle 7 → release, `timeout`=0.
- Reset asserted while blocked with `pend`=4'b0011 → `bloq_cpu`=0, `pend`=0, `sel_bios`=1 immediately, before next edge.
